// File: rtl/fp_pkg.sv
// Shared definitions for the sequential floating-point multiply/divide unit.
package fp_pkg;

    localparam int unsigned EXP_W_DEF = 8;
    localparam int unsigned MAN_W_DEF = 23;

    // Flag vector layout {invalid, divzero, overflow, underflow, inexact}
    localparam int unsigned FLAG_W  = 5;
    localparam int unsigned FLAG_NV = 4;
    localparam int unsigned FLAG_DZ = 3;
    localparam int unsigned FLAG_OF = 2;
    localparam int unsigned FLAG_UF = 1;
    localparam int unsigned FLAG_NX = 0;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } op_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        ITER  = 3'd2,
        ROUND = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Exponent bias 2^(exp_w-1)-1
    function automatic int unsigned fp_bias(input int unsigned exp_w);
        return (32'd1 << (exp_w - 32'd1)) - 32'd1;
    endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Normalize by at most one bit, round to nearest-even, and pack with
// overflow/underflow handling. Purely combinational.
module fp_round_pack
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W = EXP_W_DEF,
    parameter int unsigned MAN_W = MAN_W_DEF
) (
    input  logic                   sign,
    input  logic [EXP_W+1:0]       exponent,   // biased, two's complement
    input  logic [MAN_W+3:0]       sig,        // {2s, 1s, fraction, guard, round}
    input  logic                   sticky,
    output logic [EXP_W+MAN_W:0]   result_c,
    output logic [FLAG_W-1:0]      flags_c
);

    localparam int unsigned EW   = EXP_W + 2;
    localparam int unsigned MR_W = MAN_W + 2;
    localparam logic [EW-1:0] EXP_MAX = EW'((32'd1 << EXP_W) - 32'd1);

    logic [MAN_W:0]  mant;
    logic            g;
    logic            r;
    logic            s;
    logic [EW-1:0]   exp_n;
    logic [EW-1:0]   exp_r;
    logic [MR_W-1:0] mant_r;
    logic [MAN_W-1:0] frac_r;
    logic            round_up;
    logic            inexact;

    // Normalize, round, then range-check the final exponent
    always_comb begin
        mant     = '0;
        g        = 1'b0;
        r        = 1'b0;
        s        = 1'b0;
        exp_n    = exponent;
        if (sig[MAN_W+3]) begin
            mant  = sig[MAN_W+3:3];
            g     = sig[2];
            r     = sig[1];
            s     = sig[0] | sticky;
            exp_n = exponent + EW'(1);
        end else begin
            mant  = sig[MAN_W+2:2];
            g     = sig[1];
            r     = sig[0];
            s     = sticky;
        end

        round_up = g & (r | s | mant[0]);
        inexact  = g | r | s;
        mant_r   = {1'b0, mant} + MR_W'(round_up);
        exp_r    = exp_n + EW'(mant_r[MR_W-1]);
        frac_r   = mant_r[MR_W-1] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];

        result_c          = {sign, exp_r[EXP_W-1:0], frac_r};
        flags_c           = '0;
        flags_c[FLAG_NX]  = inexact;

        if (exp_r[EW-1] || (exp_r == '0)) begin
            result_c         = {sign, {(EXP_W+MAN_W){1'b0}}};
            flags_c[FLAG_UF] = 1'b1;
            flags_c[FLAG_NX] = 1'b1;
        end else if (exp_r >= EXP_MAX) begin
            result_c         = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_c[FLAG_OF] = 1'b1;
            flags_c[FLAG_NX] = 1'b1;
        end
    end

endmodule

// File: rtl/fp_mul_div_seq.sv
// Sequential IEEE-754-style multiply (shift-add) / divide (restoring) unit
// with valid/ready handshakes on both sides.
module fp_mul_div_seq
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W = EXP_W_DEF,
    parameter int unsigned MAN_W = MAN_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  op,
    input  logic [EXP_W+MAN_W:0]  a,
    input  logic [EXP_W+MAN_W:0]  b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [EXP_W+MAN_W:0]  result,
    output logic [FLAG_W-1:0]     flags
);

    localparam int unsigned W     = 1 + EXP_W + MAN_W;
    localparam int unsigned EW    = EXP_W + 2;
    localparam int unsigned NM    = MAN_W + 1;     // multiply iterations
    localparam int unsigned ND    = MAN_W + 4;     // divide iterations
    localparam int unsigned PW    = 2 * NM;
    localparam int unsigned SIG_W = MAN_W + 4;
    localparam int unsigned CNT_W = $clog2(ND + 1);
    localparam int unsigned BIAS  = fp_bias(EXP_W);

    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    state_t            state;
    state_t            state_d;
    op_t               op_q;
    logic [W-1:0]      a_q;
    logic [W-1:0]      b_q;
    logic [CNT_W-1:0]  cnt;
    logic [PW-1:0]     prod;
    logic [MAN_W+1:0]  rem;
    logic [ND-1:0]     quo;

    logic [EXP_W-1:0]  exp_a;
    logic [EXP_W-1:0]  exp_b;
    logic [NM-1:0]     ma;
    logic [NM-1:0]     mb;
    logic              sign_ab;
    logic              a_zero, a_inf, a_nan;
    logic              b_zero, b_inf, b_nan;
    logic              special;
    logic [W-1:0]      spec_result;
    logic [FLAG_W-1:0] spec_flags;
    logic [EW-1:0]     exp_mul;
    logic [EW-1:0]     exp_div;
    logic [NM:0]       add_sum;
    logic              div_ge;
    logic [MAN_W+1:0]  rem_sel;
    logic              last_iter;
    logic              accept;
    logic [SIG_W-1:0]  rp_sig;
    logic              rp_sticky;
    logic [EW-1:0]     rp_exp;
    logic [W-1:0]      rp_result;
    logic [FLAG_W-1:0] rp_flags;

    // Operand field decode and exponent arithmetic
    always_comb begin
        exp_a   = a_q[W-2:MAN_W];
        exp_b   = b_q[W-2:MAN_W];
        ma      = {1'b1, a_q[MAN_W-1:0]};
        mb      = {1'b1, b_q[MAN_W-1:0]};
        sign_ab = a_q[W-1] ^ b_q[W-1];
        a_zero  = (exp_a == '0);
        b_zero  = (exp_b == '0);
        a_inf   = (exp_a == '1) && (a_q[MAN_W-1:0] == '0);
        b_inf   = (exp_b == '1) && (b_q[MAN_W-1:0] == '0);
        a_nan   = (exp_a == '1) && (a_q[MAN_W-1:0] != '0);
        b_nan   = (exp_b == '1) && (b_q[MAN_W-1:0] != '0);
        exp_mul = EW'(exp_a) + EW'(exp_b) - EW'(BIAS);
        // Quotient significand is treated as one binade higher, hence the -1
        exp_div = EW'(exp_a) - EW'(exp_b) + EW'(BIAS) - EW'(1);
    end

    // Special-operand classification and their fixed results
    always_comb begin
        special     = 1'b0;
        spec_result = '0;
        spec_flags  = '0;
        if (a_nan || b_nan) begin
            special     = 1'b1;
            spec_result = QNAN;
        end else if (op_q == OP_MUL) begin
            if ((a_zero && b_inf) || (a_inf && b_zero)) begin
                special             = 1'b1;
                spec_result         = QNAN;
                spec_flags[FLAG_NV] = 1'b1;
            end else if (a_inf || b_inf) begin
                special     = 1'b1;
                spec_result = {sign_ab, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end else if (a_zero || b_zero) begin
                special     = 1'b1;
                spec_result = {sign_ab, {(W-1){1'b0}}};
            end
        end else begin
            if ((a_inf && b_inf) || (a_zero && b_zero)) begin
                special             = 1'b1;
                spec_result         = QNAN;
                spec_flags[FLAG_NV] = 1'b1;
            end else if (a_inf) begin
                special     = 1'b1;
                spec_result = {sign_ab, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end else if (b_zero) begin
                special             = 1'b1;
                spec_result         = {sign_ab, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                spec_flags[FLAG_DZ] = 1'b1;
            end else if (b_inf || a_zero) begin
                special     = 1'b1;
                spec_result = {sign_ab, {(W-1){1'b0}}};
            end
        end
    end

    // One step of shift-add multiply and restoring divide
    always_comb begin
        add_sum   = {1'b0, prod[PW-1:NM]} + (prod[0] ? {1'b0, ma} : '0);
        div_ge    = (rem >= {1'b0, mb});
        rem_sel   = div_ge ? (rem - {1'b0, mb}) : rem;
        last_iter = (op_q == OP_DIV) ? (cnt == CNT_W'(ND - 1)) : (cnt == CNT_W'(NM - 1));
        accept    = (state == IDLE) && in_valid && in_ready;
    end

    // Round-and-pack operand selection
    always_comb begin
        if (op_q == OP_DIV) begin
            rp_sig    = quo;
            rp_sticky = (rem != '0);
            rp_exp    = exp_div;
        end else begin
            rp_sig    = prod[PW-1 -: SIG_W];
            rp_sticky = (prod[PW-SIG_W-1:0] != '0);
            rp_exp    = exp_mul;
        end
    end

    fp_round_pack #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round_pack (
        .sign     (sign_ab),
        .exponent (rp_exp),
        .sig      (rp_sig),
        .sticky   (rp_sticky),
        .result_c (rp_result),
        .flags_c  (rp_flags)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (in_valid && in_ready) state_d = CHECK;
            CHECK:   state_d = special ? DONE : ITER;
            ITER:    if (last_iter) state_d = ROUND;
            ROUND:   state_d = DONE;
            DONE:    if (out_valid && out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs registered from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= (state_d == IDLE);
            out_valid <= (state_d == DONE);
        end
    end

    // Operand capture, iteration datapath and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= OP_MUL;
            a_q    <= '0;
            b_q    <= '0;
            cnt    <= '0;
            prod   <= '0;
            rem    <= '0;
            quo    <= '0;
            result <= '0;
            flags  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q <= op_t'(op);
                        a_q  <= a;
                        b_q  <= b;
                    end
                end
                CHECK: begin
                    cnt  <= '0;
                    prod <= {{NM{1'b0}}, mb};
                    rem  <= {1'b0, ma};
                    quo  <= '0;
                    if (special) begin
                        result <= spec_result;
                        flags  <= spec_flags;
                    end
                end
                ITER: begin
                    cnt <= cnt + CNT_W'(1);
                    if (op_q == OP_DIV) begin
                        rem <= rem_sel << 1;
                        quo <= {quo[ND-2:0], div_ge};
                    end else begin
                        prod <= {add_sum, prod[NM-1:1]};
                    end
                end
                ROUND: begin
                    result <= rp_result;
                    flags  <= rp_flags;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mul_div_seq.sv
// Randomized bench for fp_mul_div_seq against an exact-arithmetic model.
module tb_fp_mul_div_seq;

    localparam logic [31:0] QNAN = 32'h7FC00000;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic [4:0]  flags;

    fp_mul_div_seq #(.EXP_W(8), .MAN_W(23)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] r;
        logic [4:0]  f;
        int          lat;
        int          acc;
    } exp_t;

    exp_t pend[$];
    int   vectors = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ready_mode = 0;
    bit   seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer back-pressure: 0 always ready, 1 random, 2 stalled
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    // Exact reference: special-case table plus integer significand arithmetic
    function automatic void model(input logic o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic [4:0] f, output int lat);
        int ex, ey, e;
        logic s;
        bit xn, yn, xi, yi, xz, yz, arith, inexact;
        longint mx, my, num, den, q, rm;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        s  = x[31] ^ y[31];
        xn = (ex == 255) && (x[22:0] != 0);
        yn = (ey == 255) && (y[22:0] != 0);
        xi = (ex == 255) && (x[22:0] == 0);
        yi = (ey == 255) && (y[22:0] == 0);
        xz = (ex == 0);
        yz = (ey == 0);
        mx = longint'(x[22:0]) + (longint'(1) << 23);
        my = longint'(y[22:0]) + (longint'(1) << 23);
        r = 32'h0; f = 5'b0; lat = 2; arith = 1'b0; e = 0;
        num = 0; den = 1;
        if (xn || yn) r = QNAN;
        else if (o == 1'b0) begin
            if ((xz && yi) || (xi && yz)) begin r = QNAN; f = 5'b10000; end
            else if (xi || yi) r = {s, 8'hFF, 23'd0};
            else if (xz || yz) r = {s, 31'd0};
            else begin
                arith = 1'b1; lat = 27;
                num = mx * my;
                if (num >= (longint'(1) << 47)) begin den = longint'(1) << 24; e = ex + ey - 126; end
                else begin den = longint'(1) << 23; e = ex + ey - 127; end
            end
        end else begin
            if ((xi && yi) || (xz && yz)) begin r = QNAN; f = 5'b10000; end
            else if (xi) r = {s, 8'hFF, 23'd0};
            else if (yz) begin r = {s, 8'hFF, 23'd0}; f = 5'b01000; end
            else if (yi || xz) r = {s, 31'd0};
            else begin
                arith = 1'b1; lat = 30;
                den = my;
                if (mx >= my) begin num = mx << 23; e = ex - ey + 127; end
                else begin num = mx << 24; e = ex - ey + 126; end
            end
        end
        if (arith) begin
            q = num / den;
            rm = num % den;
            inexact = (rm != 0);
            if ((2 * rm > den) || ((2 * rm == den) && ((q % 2) == 1))) q = q + 1;
            if (q == (longint'(1) << 24)) begin q = q >> 1; e = e + 1; end
            if (e <= 0) begin r = {s, 31'd0}; f = 5'b00011; end
            else if (e >= 255) begin r = {s, 8'hFF, 23'd0}; f = 5'b00101; end
            else begin r = {s, 8'(e), 23'(q)}; f = {4'b0, inexact}; end
        end
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Pin the model against hand-computed results
    task automatic pin(input logic o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] r_req, input logic [4:0] f_req, input int lat_req);
        logic [31:0] r; logic [4:0] f; int lat;
        model(o, x, y, r, f, lat);
        chk("model_result", {32'h0, r}, {32'h0, r_req});
        chk("model_flags", {59'h0, f}, {59'h0, f_req});
        chk("model_latency", 64'(lat), 64'(lat_req));
    endtask

    task automatic send(input logic o, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] r; logic [4:0] f; int lat; int n;
        model(o, x, y, r, f, lat);
        @(negedge clk);
        op = o; a = x; b = y; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 500) begin @(negedge clk); n++; end
        if (!in_ready) begin
            vectors++; errors++;
            $display("FAIL accept_timeout: in_ready stayed %b", in_ready);
            in_valid = 1'b0;
            return;
        end
        pend.push_back('{r, f, lat, cyc});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = 1'($urandom); a = $urandom; b = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        while (pend.size() != 0 && n < 2000) begin @(negedge clk); n++; end
        if (pend.size() != 0) begin
            vectors++; errors++;
            $display("FAIL drain_timeout: %0d results outstanding", pend.size());
            pend.delete();
        end
    endtask

    function automatic logic [31:0] rnd_fp();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(15))
            0: v[30:0] = 31'd0;
            1: begin v[30:23] = 8'hFF; v[22:0] = 23'd0; end
            2: begin v[30:23] = 8'hFF; v[0] = 1'b1; end
            3: v[30:23] = 8'($urandom_range(20, 1));
            4: v[30:23] = 8'($urandom_range(254, 235));
            5: begin v[30:23] = 8'h00; v[0] = 1'b1; end
            6: begin v[30:23] = 8'($urandom_range(140, 110)); v[22:0] = 23'h7FFFFF; end
            7: begin v[30:23] = 8'($urandom_range(140, 110)); v[22:0] = 23'h0; end
            default: v[30:23] = 8'($urandom_range(190, 64));
        endcase
        return v;
    endfunction

    // Compare process: every DONE cycle is checked against the model queue
    always @(negedge clk) begin
        if (rst) begin
            seen = 1'b0;
        end else begin
            if (in_ready && out_valid) begin
                vectors++; errors++;
                $display("FAIL handshake_excl: in_ready=%b out_valid=%b", in_ready, out_valid);
            end
            if (out_valid) begin
                vectors++;
                if (pend.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_out_valid: result=%h flags=%b with nothing pending", result, flags);
                end else begin
                    if (result !== pend[0].r || flags !== pend[0].f) begin
                        errors++;
                        $display("FAIL result: got %h/%b, expected %h/%b", result, flags, pend[0].r, pend[0].f);
                    end
                    if (!seen) begin
                        vectors++;
                        if (cyc - pend[0].acc != pend[0].lat) begin
                            errors++;
                            $display("FAIL latency: got %0d, expected %0d", cyc - pend[0].acc, pend[0].lat);
                        end
                        seen = 1'b1;
                    end
                    if (out_ready) begin
                        void'(pend.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; in_valid = 1'b0; op = 1'b0; a = 32'h0; b = 32'h0;
        repeat (3) @(negedge clk);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_result", 64'(result), 64'd0);
        chk("reset_flags", 64'(flags), 64'd0);
        @(posedge clk); #1; rst = 1'b0;

        pin(1'b0, 32'h40400000, 32'h3FC00000, 32'h40900000, 5'b00000, 27);
        pin(1'b1, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 30);
        pin(1'b0, 32'h00000000, 32'h7F800000, 32'h7FC00000, 5'b10000, 2);
        pin(1'b1, 32'hBF800000, 32'h00000000, 32'hFF800000, 5'b01000, 2);
        pin(1'b0, 32'h7F000000, 32'h40000000, 32'h7F800000, 5'b00101, 27);
        pin(1'b0, 32'h00800000, 32'h3F000000, 32'h00000000, 5'b00011, 27);
        pin(1'b1, 32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 30);
        pin(1'b0, 32'h3F800001, 32'h3F800001, 32'h3F800002, 5'b00001, 27);
        pin(1'b0, 32'h7F800001, 32'h3F800000, 32'h7FC00000, 5'b00000, 2);
        pin(1'b1, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 5'b10000, 2);
        pin(1'b1, 32'h3F800000, 32'hFF800000, 32'h80000000, 5'b00000, 2);

        send(1'b0, 32'h40400000, 32'h3FC00000);
        send(1'b1, 32'h3F800000, 32'h40400000);
        send(1'b0, 32'h00000000, 32'h7F800000);
        send(1'b1, 32'hBF800000, 32'h00000000);
        send(1'b0, 32'h7F000000, 32'h40000000);
        send(1'b0, 32'h00800000, 32'h3F000000);
        send(1'b1, 32'h40C00000, 32'h40000000);
        send(1'b0, 32'h3F800001, 32'h3F800001);
        send(1'b0, 32'h7F800001, 32'h3F800000);
        send(1'b1, 32'h7F800000, 32'h7F800000);
        send(1'b1, 32'h3F800000, 32'hFF800000);
        drain();

        // Stall in DONE: result must hold and no new accept
        ready_mode = 2;
        send(1'b0, 32'h40400000, 32'h3FC00000);
        n = 0;
        while (!out_valid && n < 100) begin @(negedge clk); n++; end
        chk("stall_reached_done", 64'(out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            chk("stall_result", 64'(result), 64'h40900000);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        ready_mode = 0;
        @(negedge clk);
        chk("release_out_valid", 64'(out_valid), 64'd1);
        @(negedge clk);
        chk("post_handshake_out_valid", 64'(out_valid), 64'd0);
        chk("post_handshake_in_ready", 64'(in_ready), 64'd1);
        drain();

        // Reset in the middle of a divide
        send(1'b1, 32'h3F800000, 32'h40400000);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        pend.delete();
        chk("midreset_in_ready", 64'(in_ready), 64'd1);
        chk("midreset_out_valid", 64'(out_valid), 64'd0);
        chk("midreset_result", 64'(result), 64'd0);
        chk("midreset_flags", 64'(flags), 64'd0);
        @(negedge clk); rst = 1'b0;
        repeat (35) @(negedge clk);
        chk("aborted_no_result", 64'(out_valid), 64'd0);
        send(1'b0, 32'h40400000, 32'h3FC00000);
        drain();

        ready_mode = 1;
        for (int i = 0; i < 400; i++) begin
            send(1'($urandom), rnd_fp(), rnd_fp());
        end
        drain();
        ready_mode = 0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/fp_mul_div_seq.md
FP_MUL_DIV_SEQ -- requirements
Module: fp_mul_div_seq

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, stored fraction width; word width W = 1+EXP_W+MAN_W.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operands and op valid.
REQ-006 SHALL have port in_ready  output  1  unit idle, accepts operation.
REQ-007 SHALL have port op  input  1  0 = A*B, 1 = A/B.
REQ-008 SHALL have ports a, b  input  W  IEEE-754-style operands.
REQ-009 SHALL have port out_valid  output  1  result and flags valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port result  output  W  rounded result.
REQ-012 SHALL have port flags  output  5  {invalid, divzero, overflow, underflow, inexact}, MSB first.

Function
REQ-013 SHALL accept an operation on the cycle where in_valid && in_ready; a, b, op are registered then and later input changes are ignored.
REQ-014 SHALL use FSM states IDLE, CHECK, ITER, ROUND, DONE: IDLE->CHECK on accept; CHECK->DONE for special operands, else CHECK->ITER; ITER->ROUND after N iterations; ROUND->DONE; DONE->IDLE on out_valid && out_ready.
REQ-015 SHALL drive in_ready = 1 only in IDLE and out_valid = 1 only in DONE; no same-cycle accept while leaving DONE.
REQ-016 SHALL hold result and flags stable in DONE while out_ready is low.
REQ-017 SHALL multiply via shift-add over N = MAN_W+1 ITER cycles on {1,fraction} significands.
REQ-018 SHALL divide via restoring division over N = MAN_W+4 ITER cycles, producing normalization, guard and round bits; sticky = nonzero remainder.
REQ-019 SHALL give out_valid latency (accept cycle = 0): special cases 2; multiply MAN_W+4 (27 default); divide MAN_W+7 (30 default).
REQ-020 SHALL normalize by at most one bit, then round to nearest, ties to even; mantissa carry-out increments the exponent.
REQ-021 SHALL compute exponent with EXP_W+2 bit signed arithmetic: mul ea+eb-bias, div ea-eb+bias, bias = 2^(EXP_W-1)-1.
REQ-022 SHALL treat inputs with zero exponent as signed zero (denormals-are-zero).
REQ-023 SHALL flush results with biased exponent <= 0 after rounding to signed zero, setting underflow and inexact.
REQ-024 SHALL return signed infinity on biased exponent >= 2^EXP_W-1, setting overflow and inexact.
REQ-025 SHALL return canonical NaN (sign 0, exponent all ones, fraction MSB only) for any NaN input, 0*inf, inf/inf, 0/0; invalid set except for NaN inputs.
REQ-026 SHALL return signed infinity with divzero for finite-nonzero/0; signed zero for finite/inf and 0/finite; signed infinity for inf*finite-nonzero and inf/finite.
REQ-027 SHALL set result sign = a sign XOR b sign for all non-NaN results.
REQ-028 SHALL set inexact whenever guard, round or sticky is nonzero before rounding.

Reset
REQ-029 SHALL on rst force state IDLE, in_ready 1, out_valid 0, result 0, flags 0, clearing all datapath registers.
REQ-030 SHALL abort any in-flight operation on rst in any state, without producing a result.

Structure
REQ-031 SHALL place parameter defaults, op encoding, state enum, flag bit indices and bias computation in shared package fp_pkg.
REQ-032 SHALL implement round-and-pack (REQ-020, REQ-023, REQ-024, REQ-028) as sub-module fp_round_pack, reusable by the adder.

Verification
REQ-033 SHALL test op=0, a=0x40400000, b=0x3FC00000 -> result 0x40900000, flags 0, out_valid at cycle 27.
REQ-034 SHALL test op=1, a=0x3F800000, b=0x40400000 -> result 0x3EAAAAAB, flags inexact only, out_valid at cycle 30.
REQ-035 SHALL test op=0, a=0x00000000, b=0x7F800000 -> result 0x7FC00000, invalid, cycle 2; op=1, a=0xBF800000, b=0x00000000 -> 0xFF800000, divzero.
REQ-036 SHALL test op=0, a=0x7F000000, b=0x40000000 -> 0x7F800000, overflow+inexact; op=0, a=0x00800000, b=0x3F000000 -> 0x00000000, underflow+inexact.
REQ-037 SHALL test out_ready held low 5 cycles in DONE -> result stable, in_ready 0, then single-cycle handshake returns to IDLE.
REQ-038 SHALL test rst asserted mid-ITER -> outputs at reset values next edge, following accepted operation completes correctly.
